barrett_reduce: RTL and testbench



---
 rtl/barrett_reduce.sv | 92 +++++++++
 tb/tb_barrett_reduce.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/barrett_reduce.sv
// Three-stage pipelined Barrett reducer: 2k-bit product in, canonical residue mod q out.
// Optional input range check (x >= q*q flagged on out_err) enabled by BARRETT_RANGE_CHECK_EN.
module barrett_reduce #(
  parameter int DATA_WIDTH = 8,
  parameter int MODULUS    = 251
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_err
);

  localparam int K = DATA_WIDTH;
  localparam logic [2*K:0]   POW2_2K  = {1'b1, {(2*K){1'b0}}};
  localparam logic [2*K:0]   MOD_WIDE = (2*K+1)'(MODULUS);
  localparam logic [2*K:0]   MU_WIDE  = POW2_2K / MOD_WIDE;
  localparam logic [K:0]     MU       = (K+1)'(MU_WIDE);
  localparam logic [K+1:0]   Q_1X     = (K+2)'(MODULUS);
  localparam logic [K+1:0]   Q_2X     = (K+2)'(2 * MODULUS);
`ifdef BARRETT_RANGE_CHECK_EN
  localparam logic [2*K-1:0] Q_SQ     = (2*K)'(MODULUS * MODULUS);
`endif

  logic           en_s;
  logic [2*K+1:0] t1_s;
  logic [K+1:0]   r_s;
  logic [K-1:0]   red_s;
  logic           err_s;

  logic           s1_valid_r;
  logic [K+1:0]   s1_x_r;
  logic [K:0]     s1_qest_r;
  logic           s1_err_r;
  logic           s2_valid_r;
  logic [K+1:0]   s2_r_r;
  logic           s2_err_r;

  // Stall control, Barrett arithmetic and final conditional subtraction.
  always_comb begin
    en_s     = !(out_valid && !out_ready);
    in_ready = en_s;
    t1_s     = (2*K+2)'(in_data >> (K-1)) * (2*K+2)'(MU);
    // r < 3q fits in k+2 bits, so the low k+2 bits of x and q_est*q are enough.
    r_s      = s1_x_r - ({1'b0, s1_qest_r} * Q_1X);
    if (s2_r_r >= Q_2X) begin
      red_s = K'(s2_r_r - Q_2X);
    end else if (s2_r_r >= Q_1X) begin
      red_s = K'(s2_r_r - Q_1X);
    end else begin
      red_s = K'(s2_r_r);
    end
`ifdef BARRETT_RANGE_CHECK_EN
    err_s = (in_data >= Q_SQ);
`else
    err_s = 1'b0;
`endif
  end

  // Pipeline registers; every stage advances together only when the output is not stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_x_r     <= '0;
      s1_qest_r  <= '0;
      s1_err_r   <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_r_r     <= '0;
      s2_err_r   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
    end else if (en_s) begin
      s1_valid_r <= in_valid;
      s1_x_r     <= (K+2)'(in_data);
      // Only the quotient estimate t1 >> (k+1) is needed downstream.
      s1_qest_r  <= (K+1)'(t1_s >> (K+1));
      s1_err_r   <= err_s;
      s2_valid_r <= s1_valid_r;
      s2_r_r     <= r_s;
      s2_err_r   <= s1_err_r;
      out_valid  <= s2_valid_r;
      out_data   <= red_s;
      out_err    <= s2_err_r;
    end
  end

endmodule

// File: tb/tb_barrett_reduce.sv
// Self-checking bench for barrett_reduce: directed, backpressure, reset-flush and randomized sweeps
// against an item-level model (each item becomes visible after three advancing clock edges).
module tb_barrett_reduce;

  localparam int Q   = 251;
  localparam int QSQ = Q * Q;
`ifdef BARRETT_RANGE_CHECK_EN
  localparam bit RANGE = 1'b1;
`else
  localparam bit RANGE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_err;

  int errors = 0;
  int checks = 0;
  int q_x[$];
  int q_adv[$];

  barrett_reduce dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic v, input int x, input logic ordy, input logic rst, output logic acc);
    logic exp_ov;
    logic exp_rdy;
    @(negedge clk);
    exp_ov = (q_x.size() > 0) && (q_adv[0] >= 3);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_err", 32'(out_err), 32'(RANGE && (q_x[0] >= QSQ)));
      if (q_x[0] < QSQ) chk("out_data", 32'(out_data), 32'(q_x[0] % Q));
    end
    in_valid  = v;
    in_data   = x[15:0];
    out_ready = ordy;
    reset     = rst;
    #1;
    exp_rdy = !(exp_ov && !ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy && !rst;
    if (rst) begin
      q_x.delete();
      q_adv.delete();
    end else if (exp_rdy) begin
      if (exp_ov && ordy) begin
        void'(q_x.pop_front());
        void'(q_adv.pop_front());
      end
      foreach (q_adv[i]) q_adv[i] = q_adv[i] + 1;
      if (v) begin
        q_x.push_back(x);
        q_adv.push_back(1);
      end
    end
  endtask

  initial begin
    logic acc;
    int   x;
    int   n;
    int   cyc;
    int   dir_a[4] = '{2, 1, 231, 23100};
    int   dir_b[5] = '{0, 250, 251, 62500, 63000};

    reset = 1'b1; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_err", 32'(out_err), 32'd0);
    step(1'b0, 0, 1'b1, 1'b0, acc);

    // Back-to-back directed values, then boundary values.
    foreach (dir_a[i]) step(1'b1, dir_a[i], 1'b1, 1'b0, acc);
    foreach (dir_b[i]) step(1'b1, dir_b[i], 1'b1, 1'b0, acc);
    repeat (5) step(1'b0, 0, 1'b1, 1'b0, acc);

    // Backpressure: out_ready pattern 1-0-0-1 over a 10-item stream.
    n = 0;
    cyc = 0;
    while ((n < 10 || q_x.size() > 0) && cyc < 200) begin
      step(n < 10, 1000 + n * 517, (cyc % 4 == 0) || (cyc % 4 == 3), 1'b0, acc);
      if (acc) n++;
      cyc++;
    end

    // Reset while three items are in flight and the output is stalled.
    step(1'b1, 4001, 1'b0, 1'b0, acc);
    step(1'b1, 4002, 1'b0, 1'b0, acc);
    step(1'b1, 4003, 1'b0, 1'b0, acc);
    step(1'b0, 0, 1'b0, 1'b1, acc);
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (6) step(1'b0, 0, 1'b1, 1'b0, acc);

    // Random valid/ready over a contiguous low range.
    x = 0;
    cyc = 0;
    while (x < 3000 && cyc < 20000) begin
      step($urandom_range(3) != 0, x, $urandom_range(3) != 0, 1'b0, acc);
      if (acc) x++;
      cyc++;
    end
    repeat (6) step(1'b0, 0, 1'b1, 1'b0, acc);

    // Full-rate sweep of the nominal range [0, q*q-1] in steps of 3.
    for (int v = 0; v < QSQ; v += 3) step(1'b1, v, 1'b1, 1'b0, acc);

    // Out-of-range inputs: flagged only in the range-check build.
    step(1'b1, 63001, 1'b1, 1'b0, acc);
    step(1'b1, 65535, 1'b1, 1'b0, acc);
    step(1'b1, 63000, 1'b1, 1'b0, acc);
    repeat (6) step(1'b0, 0, 1'b1, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
